// File: rtl/g_capture_pkg.sv
// Shared constants for the G event-capture block: count width and the
// {timestamp, count} entry layout used by the FIFO and the read port.
package g_capture_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_LSB = 0;
    localparam int unsigned TS_LSB  = CNT_W;

    localparam int unsigned DROP_CNT_W   = 8;
    localparam int unsigned DROP_CNT_MAX = (1 << DROP_CNT_W) - 1;

    function automatic int unsigned entry_w(input int unsigned ts_w);
        return ts_w + CNT_W;
    endfunction

endpackage

// File: rtl/g_event_capture_if.sv
// Event input and host read port of g_event_capture.
// The master modport is the capture block; the slave modport is the controller/host side.
interface g_event_capture_if
    import g_capture_pkg::*;
#(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic                        g;
    logic [CNT_W-1:0]            count;
    logic                        rd_valid;
    logic                        rd_ready;
    logic [entry_w(TS_W)-1:0]    rd_data;
    logic [LVL_W-1:0]            level;
    logic                        overflow;
    logic                        ovf_clr;

    modport master (
        input  g, count, rd_ready, ovf_clr,
        output rd_valid, rd_data, level, overflow
    );

    modport slave (
        output g, count, rd_ready, ovf_clr,
        input  rd_valid, rd_data, level, overflow
    );

endinterface

// File: rtl/g_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two >= 2.
// Pointers carry an extra wrap bit so full/empty/level fall out of a plain compare.
module g_capture_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic push_eff;
    logic pop_eff;

    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        level_o = wr_ptr_q - rd_ptr_q;
        rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop_eff  = pop_i & ~empty_o;
        push_eff = push_i & (~full_o | pop_eff);
        wr_ptr_d = wr_ptr_q + (push_eff ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop_eff ? PTR_W'(1) : PTR_W'(0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/g_event_capture.sv
// Timestamps each rising edge of G and queues {timestamp, count} for a host.
// Define G_CAPTURE_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module g_event_capture
    import g_capture_pkg::*;
#(
    parameter int unsigned TS_W  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    clear_i,
    g_event_capture_if.master       cap_if
`ifdef G_CAPTURE_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
`endif
);

    localparam int unsigned ENTRY_W = entry_w(TS_W);

    logic [TS_W-1:0]    ts_q, ts_d;
    logic               g_q;
    logic               overflow_q, overflow_d;
    logic               edge_det;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] entry;

    always_comb begin
        ts_d     = ts_q + TS_W'(1);
        edge_det = cap_if.g & ~g_q;
        pop      = ~fifo_empty & cap_if.rd_ready;
        drop     = edge_det & fifo_full & ~pop;

        entry                         = '0;
        entry[TS_LSB +: TS_W]         = ts_q;
        entry[CNT_LSB +: CNT_W]       = cap_if.count;

        // A drop in the same cycle as ovf_clr keeps the flag set.
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (cap_if.ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            ts_q       <= '0;
            g_q        <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            g_q        <= cap_if.g;
            overflow_q <= overflow_d;
        end
    end

    g_capture_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (clear_i),
        .push_i  (edge_det),
        .wdata_i (entry),
        .pop_i   (cap_if.rd_ready),
        .rdata_o (cap_if.rd_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (cap_if.level)
    );

    assign cap_if.rd_valid = ~fifo_empty;
    assign cap_if.overflow = overflow_q;

`ifdef G_CAPTURE_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (cap_if.ovf_clr) begin
                drop_cnt_d = DROP_CNT_W'(1);
            end else if (drop_cnt_q != DROP_CNT_W'(DROP_CNT_MAX)) begin
                drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
            end
        end else if (cap_if.ovf_clr) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_g_event_capture.sv
// Scoreboard bench for g_event_capture: a 16-bit-timestamp instance (A) and a
// 4-bit-timestamp instance (B) for the wrap and mid-drain clear cases.
module tb_g_event_capture;

    logic clk;
    logic clk_en;
    logic clear_a;
    logic clear_b;

    int n_checks;
    int n_errors;

    logic [19:0] qa[$];
    logic [7:0]  qb[$];
    logic [15:0] ts_m;

    g_event_capture_if #(.TS_W(16), .DEPTH(4)) a_if ();
    g_event_capture_if #(.TS_W(4),  .DEPTH(4)) b_if ();

`ifdef G_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_a;
    logic [7:0] drop_b;
`endif

    g_event_capture #(.TS_W(16), .DEPTH(4)) dut_a (
        .clk_i      (clk),
        .clear_i    (clear_a),
        .cap_if     (a_if.master)
`ifdef G_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_a)
`endif
    );

    g_event_capture #(.TS_W(4), .DEPTH(4)) dut_b (
        .clk_i      (clk),
        .clear_i    (clear_b),
        .cap_if     (b_if.master)
`ifdef G_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt_o (drop_b)
`endif
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
        end
    end

    // Reference timestamp for instance A.
    always @(posedge clk or posedge clear_a) begin
        if (clear_a) ts_m <= '0;
        else         ts_m <= ts_m + 16'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop the expected entry whenever a read handshake is presented.
    always @(negedge clk) begin
        logic [19:0] e;
        if (!clear_a && a_if.rd_valid && a_if.rd_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_entry: got %h, required no entry", a_if.rd_data);
            end else begin
                e = qa.pop_front();
                check("a_rd_data", 32'(a_if.rd_data), 32'(e));
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (!clear_b && b_if.rd_valid && b_if.rd_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_entry: got %h, required no entry", b_if.rd_data);
            end else begin
                e = qb.pop_front();
                check("b_rd_data", 32'(b_if.rd_data), 32'(e));
            end
        end
    end

    task automatic edge_a(input logic [3:0] c, input bit lands);
        a_if.g     = 1'b1;
        a_if.count = c;
        if (lands) qa.push_back({ts_m, c});
        tick();
        a_if.g = 1'b0;
        tick();
    endtask

    task automatic drain_a(input int n);
        a_if.rd_ready = 1'b1;
        repeat (n) tick();
        a_if.rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk_en   = 1'b0;
        a_if.g = 1'b0; a_if.count = '0; a_if.rd_ready = 1'b0; a_if.ovf_clr = 1'b0;
        b_if.g = 1'b0; b_if.count = '0; b_if.rd_ready = 1'b0; b_if.ovf_clr = 1'b0;
        clear_a = 1'b1;
        clear_b = 1'b1;

        // Reset state with no clock running.
        #1;
        check("rst_rd_valid", 32'(a_if.rd_valid), 32'd0);
        check("rst_rd_data",  32'(a_if.rd_data),  32'd0);
        check("rst_level",    32'(a_if.level),    32'd0);
        check("rst_overflow", 32'(a_if.overflow), 32'd0);
        check("rst_b_level",  32'(b_if.level),    32'd0);
`ifdef G_CAPTURE_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_a), 32'd0);
`endif
        clk_en = 1'b1;
        tick();
        tick();

        // First capture at ts=5, one-cycle latency.
        clear_a = 1'b0;
        repeat (5) tick();
        a_if.g = 1'b1; a_if.count = 4'hF;
        qa.push_back(20'h0005F);
        tick();
        a_if.g = 1'b0;
        check("t2_rd_valid", 32'(a_if.rd_valid), 32'd1);
        check("t2_rd_data",  32'(a_if.rd_data),  32'h0005F);
        check("t2_level",    32'(a_if.level),    32'd1);
        drain_a(1);
        check("t2_rd_valid_after_pop", 32'(a_if.rd_valid), 32'd0);
        check("t2_level_after_pop",    32'(a_if.level),    32'd0);
        check("t2_rd_data_empty",      32'(a_if.rd_data),  32'd0);

        // Level-high G yields a single entry.
        a_if.g = 1'b1; a_if.count = 4'h3;
        qa.push_back({ts_m, 4'h3});
        repeat (10) tick();
        a_if.g = 1'b0;
        tick();
        check("t3_level", 32'(a_if.level), 32'd1);
        drain_a(1);
        check("t3_level_after_pop", 32'(a_if.level), 32'd0);

        // Five edges into a 4-deep FIFO; the fifth drops while ovf_clr is high.
        edge_a(4'h1, 1'b1);
        edge_a(4'h2, 1'b1);
        edge_a(4'h3, 1'b1);
        edge_a(4'h4, 1'b1);
        check("t4_level_full",   32'(a_if.level),    32'd4);
        check("t4_no_overflow",  32'(a_if.overflow), 32'd0);
        a_if.g = 1'b1; a_if.count = 4'h5; a_if.ovf_clr = 1'b1;
        tick();
        a_if.g = 1'b0; a_if.ovf_clr = 1'b0;
        check("t4_level_after_drop", 32'(a_if.level),    32'd4);
        check("t4_overflow_set",     32'(a_if.overflow), 32'd1);
`ifdef G_CAPTURE_DROP_CNT_EN
        check("t4_drop_cnt", 32'(drop_a), 32'd1);
`endif
        tick();
        a_if.ovf_clr = 1'b1;
        tick();
        a_if.ovf_clr = 1'b0;
        check("t4_overflow_cleared", 32'(a_if.overflow), 32'd0);
`ifdef G_CAPTURE_DROP_CNT_EN
        check("t4_drop_cnt_cleared", 32'(drop_a), 32'd0);
`endif
        drain_a(4);
        check("t4_level_drained", 32'(a_if.level), 32'd0);

        // Full FIFO, push and pop together.
        edge_a(4'h6, 1'b1);
        edge_a(4'h7, 1'b1);
        edge_a(4'h8, 1'b1);
        edge_a(4'h9, 1'b1);
        a_if.g = 1'b1; a_if.count = 4'hA; a_if.rd_ready = 1'b1;
        qa.push_back({ts_m, 4'hA});
        tick();
        a_if.g = 1'b0; a_if.rd_ready = 1'b0;
        check("t5_level_stays", 32'(a_if.level),    32'd4);
        check("t5_no_overflow", 32'(a_if.overflow), 32'd0);
        tick();
        drain_a(4);
        check("t5_level_drained", 32'(a_if.level), 32'd0);

        // Empty FIFO, push with rd_ready high: pop ignored.
        a_if.g = 1'b1; a_if.count = 4'hB; a_if.rd_ready = 1'b1;
        qa.push_back({ts_m, 4'hB});
        tick();
        a_if.g = 1'b0; a_if.rd_ready = 1'b0;
        check("e_level",    32'(a_if.level),    32'd1);
        check("e_rd_valid", 32'(a_if.rd_valid), 32'd1);
        drain_a(1);
        check("e_level_drained", 32'(a_if.level), 32'd0);

        // Instance B: 4-bit timestamp wrap.
        tick();
        clear_b = 1'b0;
        repeat (15) tick();
        b_if.g = 1'b1; b_if.count = 4'hC;
        qb.push_back(8'hFC);
        tick();
        b_if.g = 1'b0;
        tick();
        b_if.g = 1'b1; b_if.count = 4'hD;
        qb.push_back(8'h1D);
        tick();
        check("t6_level_two", 32'(b_if.level), 32'd2);
        b_if.rd_ready = 1'b1;
        tick();
        b_if.rd_ready = 1'b0;
        check("t6_level_one", 32'(b_if.level), 32'd1);

        // Asynchronous clear mid-drain with G still high.
        #2 clear_b = 1'b1;
        #1;
        check("t6_clear_rd_valid", 32'(b_if.rd_valid), 32'd0);
        check("t6_clear_level",    32'(b_if.level),    32'd0);
        check("t6_clear_rd_data",  32'(b_if.rd_data),  32'd0);
        qb.delete();
        #2 clear_b = 1'b0;
        qb.push_back(8'h0D);
        tick();
        check("t6_recapture_valid", 32'(b_if.rd_valid), 32'd1);
        check("t6_recapture_level", 32'(b_if.level),    32'd1);
        b_if.rd_ready = 1'b1;
        tick();
        b_if.rd_ready = 1'b0;
        b_if.g = 1'b0;
        check("t6_level_drained", 32'(b_if.level), 32'd0);

        tick();
        check("a_scoreboard_empty", 32'(qa.size()), 32'd0);
        check("b_scoreboard_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
